// File: rtl/fifo_pack_gearbox.sv
// fifo_pack_gearbox
//   Drains narrow words from an upstream one-entry FIFO stage (first/deq interface)
//   and packs RATIO consecutive words into one wide word. The wide word is presented
//   to the next stage on an enq-style handshake. Lane 0 holds the first word received
//   and sits in the least significant bits.
//
// Optional feature macro: PACK_FLUSH_EN
//   When defined, adds a flush request that emits a partial (zero-padded) word and a
//   lane-count output that travels with every emitted word.
//
// Ports
//   CLK            in   clock, all state on posedge
//   RST            in   asynchronous active-high reset
//   in_first       in   upstream head word
//   in_first__RDY  in   upstream head valid
//   in_deq__RDY    in   upstream can dequeue
//   in_deq__ENA    out  dequeue strobe to upstream
//   out_enq__RDY   in   downstream can accept
//   out_enq__ENA   out  wide word transfer strobe
//   out_enq_v      out  wide word (registered)
//   flush__ENA     in   (PACK_FLUSH_EN) request emission of a partial word
//   flush__RDY     out  (PACK_FLUSH_EN) flush accepted this cycle when high
//   out_enq_lanes  out  (PACK_FLUSH_EN) valid lane count of out_enq_v

module fifo_pack_gearbox #(
   parameter int unsigned width = 32,
   parameter int unsigned RATIO = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [width-1:0]           in_first,
   input  logic                       in_first__RDY,
   input  logic                       in_deq__RDY,
   output logic                       in_deq__ENA,
   input  logic                       out_enq__RDY,
   output logic                       out_enq__ENA,
`ifdef PACK_FLUSH_EN
   input  logic                       flush__ENA,
   output logic                       flush__RDY,
   output logic [$clog2(RATIO):0]     out_enq_lanes,
`endif
   output logic [width*RATIO-1:0]     out_enq_v
);

   localparam int unsigned CntW  = $clog2(RATIO);
   localparam int unsigned WideW = width * RATIO;
   localparam logic [CntW-1:0] LastLane = CntW'(RATIO - 1);

   logic [WideW-1:0] acc_q, acc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             hold_q, hold_d;

   logic emit;
   logic pull_ok;
   logic pull;
   logic flush_req;

`ifdef PACK_FLUSH_EN
   localparam int unsigned LaneW = CntW + 1;
   logic [LaneW-1:0] lanes_q, lanes_d;
   logic             flush_fire;

   assign flush_req  = flush__ENA;
   assign flush__RDY = ~hold_q & ~RST;
   assign flush_fire = flush__ENA & flush__RDY;
   assign out_enq_lanes = lanes_q;
`else
   assign flush_req = 1'b0;
`endif

   // Reset gating keeps both strobes low while RST is asserted, independent of state.
   assign emit    = hold_q & out_enq__RDY & ~RST;
   // A pending wide word leaves this cycle, so the accumulator may be refilled now.
   assign pull_ok = ~hold_q | emit;
   // A flush request blocks the dequeue so a flush cycle never mixes in a new lane.
   assign pull    = in_first__RDY & in_deq__RDY & pull_ok & ~flush_req & ~RST;

   assign in_deq__ENA  = pull;
   assign out_enq__ENA = emit;
   assign out_enq_v    = acc_q;

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      hold_d = hold_q;
`ifdef PACK_FLUSH_EN
      lanes_d = lanes_q;
`endif

      if (emit) begin
         hold_d = 1'b0;
      end

      if (pull) begin
         for (int i = 0; i < int'(RATIO); i++) begin
            if (cnt_q == CntW'(i)) begin
               acc_d[i*width +: width] = in_first;
            end
         end
         if (cnt_q == LastLane) begin
            // Completion overrides an emit in the same cycle: hold stays set for the new word.
            cnt_d  = '0;
            hold_d = 1'b1;
`ifdef PACK_FLUSH_EN
            lanes_d = LaneW'(RATIO);
`endif
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end

`ifdef PACK_FLUSH_EN
      // Flush with an empty accumulator is accepted but does nothing.
      if (flush_fire && (cnt_q != '0)) begin
         for (int i = 0; i < int'(RATIO); i++) begin
            if (CntW'(i) >= cnt_q) begin
               acc_d[i*width +: width] = '0;
            end
         end
         hold_d  = 1'b1;
         lanes_d = {1'b0, cnt_q};
         cnt_d   = '0;
      end
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         hold_q <= 1'b0;
`ifdef PACK_FLUSH_EN
         lanes_q <= '0;
`endif
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
`ifdef PACK_FLUSH_EN
         lanes_q <= lanes_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_pack_gearbox.sv
// tb_fifo_pack_gearbox
//   Randomized and directed stimulus for fifo_pack_gearbox (width=8, RATIO=4).
//   A reference model tracks received narrow words and pending wide words; completed
//   wide words go into a scoreboard queue that a separate monitor drains on each emit.

module tb_fifo_pack_gearbox;

   localparam int unsigned W = 8;
   localparam int unsigned R = 4;

   typedef struct packed {
      logic [W*R-1:0] v;
      logic [2:0]     lanes;
   } exp_t;

   logic           CLK;
   logic           RST;
   logic [W-1:0]   first;
   logic           first_rdy;
   logic           deq_rdy;
   logic           deq_ena;
   logic           out_rdy;
   logic           out_ena;
   logic [W*R-1:0] out_v;
   logic           flush_ena;
`ifdef PACK_FLUSH_EN
   logic           flush_rdy;
   logic [2:0]     out_lanes;
`endif

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   fifo_pack_gearbox #(
      .width(W),
      .RATIO(R)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .in_first      (first),
      .in_first__RDY (first_rdy),
      .in_deq__RDY   (deq_rdy),
      .in_deq__ENA   (deq_ena),
      .out_enq__RDY  (out_rdy),
      .out_enq__ENA  (out_ena),
`ifdef PACK_FLUSH_EN
      .flush__ENA    (flush_ena),
      .flush__RDY    (flush_rdy),
      .out_enq_lanes (out_lanes),
`endif
      .out_enq_v     (out_v)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] part[$];
   int           pend;
   logic         push;
   exp_t         new_e;
   logic         m_ena, m_deq, m_frdy;

   function automatic exp_t pack_words(input int n);
      exp_t e;
      e.v = '0;
      for (int i = 0; i < n; i++) e.v[i*W +: W] = part[i];
      e.lanes = 3'(n);
      return e;
   endfunction

   initial begin
      pend = 0;
      forever begin
         @(negedge CLK);
         push = 1'b0;
         if (RST) begin
            chk("deq_in_reset", 64'(deq_ena), 64'd0);
            chk("ena_in_reset", 64'(out_ena), 64'd0);
`ifdef PACK_FLUSH_EN
            chk("flush_rdy_in_reset", 64'(flush_rdy), 64'd0);
`endif
            pend = 0;
            part.delete();
            exp_q.delete();
         end else begin
            m_ena  = (pend > 0) && out_rdy;
            m_frdy = (pend == 0);
            m_deq  = first_rdy && deq_rdy && ((pend == 0) || m_ena) && !flush_ena;
            chk("out_ena", 64'(out_ena), 64'(m_ena));
            chk("deq_ena", 64'(deq_ena), 64'(m_deq));
`ifdef PACK_FLUSH_EN
            chk("flush_rdy", 64'(flush_rdy), 64'(m_frdy));
`endif
            if (m_ena) pend--;
            if (m_deq) begin
               part.push_back(first);
               if (part.size() == R) begin
                  new_e = pack_words(R);
                  push = 1'b1;
                  part.delete();
               end
            end
            if (flush_ena && m_frdy && part.size() > 0) begin
               new_e = pack_words(part.size());
               push = 1'b1;
               part.delete();
            end
            if (push) pend++;
         end
         // Publish the new word only once the DUT has registered it.
         @(posedge CLK);
         if (push && !RST) exp_q.push_back(new_e);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            if (out_ena) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_emit", 64'(out_v), 64'hDEAD_BEEF_0000);
               end else begin
                  e = exp_q.pop_front();
                  chk("wide_word", 64'(out_v), 64'(e.v));
`ifdef PACK_FLUSH_EN
                  chk("lanes", 64'(out_lanes), 64'(e.lanes));
`endif
               end
            end else if (exp_q.size() > 0) begin
               chk("held_word", 64'(out_v), 64'(exp_q[0].v));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic [W-1:0] d, input logic fr, input logic dr, input logic orr,
                      input logic fl);
      first     = d;
      first_rdy = fr;
      deq_rdy   = dr;
      out_rdy   = orr;
      flush_ena = fl;
      @(posedge CLK);
      #1;
   endtask

   logic fl_rand;

   initial begin
      RST = 1'b1;
      first = '0; first_rdy = 1'b0; deq_rdy = 1'b0; out_rdy = 1'b0; flush_ena = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      cyc(8'h00, 0, 0, 1, 0);

      // Basic pack: 11,22,33,44 -> 0x44332211
      cyc(8'h11, 1, 1, 1, 0);
      cyc(8'h22, 1, 1, 1, 0);
      cyc(8'h33, 1, 1, 1, 0);
      cyc(8'h44, 1, 1, 1, 0);
      repeat (3) cyc(8'h00, 0, 0, 1, 0);

      // Streaming: 16 back-to-back words
      for (int i = 0; i < 16; i++) cyc(8'($urandom), 1, 1, 1, 0);
      repeat (2) cyc(8'h00, 0, 0, 1, 0);

      // Back-pressure: full word, then 10 stalled cycles with upstream valid
      for (int i = 0; i < 4; i++) cyc(8'($urandom), 1, 1, 0, 0);
      for (int i = 0; i < 10; i++) cyc(8'($urandom), 1, 1, 0, 0);
      for (int i = 0; i < 8; i++) cyc(8'($urandom), 1, 1, 1, 0);

      // Downstream ready only in sparse single cycles while upstream streams
      for (int i = 0; i < 40; i++) cyc(8'($urandom), 1, 1, (i % 5) == 4, 0);

      // Reset mid-packing with upstream valid and a word pending
      for (int i = 0; i < 6; i++) cyc(8'($urandom), 1, 1, 0, 0);
      RST = 1'b1;
      for (int i = 0; i < 3; i++) cyc(8'($urandom), 1, 1, 1, 0);
      RST = 1'b0;
      repeat (3) cyc(8'h00, 0, 0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
`ifdef PACK_FLUSH_EN
         fl_rand = ($urandom_range(0, 9) == 0);
`else
         fl_rand = 1'b0;
`endif
         cyc(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) != 0, fl_rand);
      end

`ifdef PACK_FLUSH_EN
      // Clear any partial word, then AA,BB + flush -> 0x0000BBAA with 2 lanes
      repeat (2) cyc(8'h00, 0, 0, 1, 1);
      repeat (2) cyc(8'h00, 0, 0, 1, 0);
      cyc(8'hAA, 1, 1, 1, 0);
      cyc(8'hBB, 1, 1, 1, 0);
      cyc(8'hCC, 1, 1, 0, 1);
      repeat (2) cyc(8'h00, 0, 0, 0, 0);
      repeat (2) cyc(8'h00, 0, 0, 1, 0);
      // Flush with nothing accumulated: accepted, no emission
      cyc(8'h00, 0, 0, 1, 1);
      repeat (3) cyc(8'h00, 0, 0, 1, 0);
`endif

      // Drain
      repeat (10) cyc(8'h00, 0, 0, 1, 0);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
